// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and the double-dabble step
// for the shared binary-to-BCD conversion engine.
package bcd_pkg;

    localparam int BIN_W      = 8;
    localparam int BCD_DIGITS = 3;
    localparam int SHIFT_W    = 20;
    localparam int N_ITER     = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // One iteration: bias every BCD nibble >= 5 by 3, then shift left.
    function automatic logic [SHIFT_W-1:0] add3_adjust(
        input logic [SHIFT_W-1:0] s
    );
        logic [SHIFT_W-1:0] t;
        t = s;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (t[BIN_W+4*d +: 4] >= 4'd5)
                t[BIN_W+4*d +: 4] = t[BIN_W+4*d +: 4] + 4'd3;
        end
        return {t[SHIFT_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/bcd_conv_arbiter_if.sv
// Request/result bundle between the requesters and the
// shared BCD conversion engine.
interface bcd_conv_arbiter_if #(
    parameter int N_CH = 4
);
    localparam int CW = $clog2(N_CH);

    logic [N_CH-1:0]   req;
    logic [N_CH*8-1:0] bin_flat;
    logic [N_CH-1:0]   ack;
    logic              busy;
    logic              out_valid;
    logic [CW-1:0]     out_ch;
    logic [3:0]        bcd2;
    logic [3:0]        bcd1;
    logic [3:0]        bcd0;

    modport master (
        output req, bin_flat,
        input  ack, busy, out_valid, out_ch,
        input  bcd2, bcd1, bcd0
    );

    modport slave (
        input  req, bin_flat,
        output ack, busy, out_valid, out_ch,
        output bcd2, bcd1, bcd0
    );

endinterface

// File: rtl/bcd_conv_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request
// at or above ptr, wrapping modulo N_CH.
module rr_arbiter #(
    parameter int N_CH = 4,
    parameter int CW   = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CW-1:0]   ptr,
    output logic [N_CH-1:0] grant,
    output logic [CW-1:0]   idx,
    output logic            any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            automatic int k = (int'(ptr) + i) % N_CH;
            if (!any && req[k]) begin
                any      = 1'b1;
                idx      = CW'(k);
                grant[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Shared 8-bit binary to 3-digit BCD converter with
// round-robin channel arbitration.
module bcd_conv_arbiter
    import bcd_pkg::*;
#(
    parameter int N_CH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    bcd_conv_arbiter_if.slave   bus
);

    localparam int CW = $clog2(N_CH);

    state_t             state;
    logic [SHIFT_W-1:0] sreg;
    logic [SHIFT_W-1:0] nxt;
    logic [2:0]         cnt;
    logic [CW-1:0]      ptr;
    logic [CW-1:0]      ch;
    logic [CW-1:0]      gidx;
    logic [N_CH-1:0]    grant;
    logic               any;

    rr_arbiter #(.N_CH(N_CH), .CW(CW)) u_arb (
        .req   (bus.req),
        .ptr   (ptr),
        .grant (grant),
        .idx   (gidx),
        .any   (any)
    );

    assign nxt = add3_adjust(sreg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            sreg          <= '0;
            cnt           <= '0;
            ptr           <= '0;
            ch            <= '0;
            bus.ack       <= '0;
            bus.busy      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_ch    <= '0;
            bus.bcd2      <= '0;
            bus.bcd1      <= '0;
            bus.bcd0      <= '0;
        end else begin
            bus.ack       <= '0;
            bus.out_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any) begin
                        sreg     <= {12'd0,
                            bus.bin_flat[int'(gidx)*BIN_W +: BIN_W]};
                        cnt      <= '0;
                        bus.ack  <= grant;
                        ch       <= gidx;
                        ptr      <= (gidx == CW'(N_CH-1)) ?
                                    '0 : gidx + CW'(1);
                        bus.busy <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    sreg <= nxt;
                    cnt  <= cnt + 3'd1;
                    // Digits are loaded as we enter DONE so they
                    // are visible alongside out_valid.
                    if (cnt == 3'(N_ITER-1)) begin
                        state         <= DONE;
                        bus.bcd2      <= nxt[19:16];
                        bus.bcd1      <= nxt[15:12];
                        bus.bcd0      <= nxt[11:8];
                        bus.out_ch    <= ch;
                        bus.out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/bcd_conv_arbiter.md
# bcd_conv_arbiter

Sequential binary-to-BCD conversion engine shared by up to N_CH requesters (DAC code, setpoint, readback, etc.) feeding the 3-digit decimal display path. A round-robin arbiter grants one channel at a time. The block captures that channel's 8-bit value and runs the shift-add-3 algorithm over 8 clock cycles. It then presents the registered hundreds/tens/units digits with a one-cycle valid strobe tagged by channel.

## Interface
- N_CH, 4, number of requesting channels (2..8)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  N_CH  per-channel conversion request, level; hold with bin until ack
- bin_flat  in  N_CH*8  channel k value at bin_flat[8k+7:8k], unsigned 0..255
- ack  out  N_CH  one-hot, one-cycle pulse: channel's value captured
- busy  out  1  high whenever state != IDLE
- out_valid  out  1  one-cycle pulse: bcd2/bcd1/bcd0 and out_ch are new
- out_ch  out  $clog2(N_CH)  channel index of the current result
- bcd2  out  4  hundreds digit, 0..2
- bcd1  out  4  tens digit, 0..9
- bcd0  out  4  units digit, 0..9

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE, req == 0: stay.
- IDLE, req != 0: winner = first asserted channel at or after pointer ptr, searching upward modulo N_CH.
  - Load the 20-bit shift register with {12'd0, bin[winner]} and set cnt = 0.
  - Pulse ack[winner] and latch winner into the channel register.
  - Set ptr = (winner+1) mod N_CH, then go to SHIFT.
- SHIFT, per cycle: for each BCD nibble [11:8], [15:12], [19:16], add 3 if the nibble is >= 5. Then shift the whole register left by 1 and increment cnt.
  - After the 8th iteration (cnt == 7), go to DONE.
- DONE: bcd2/bcd1/bcd0 take the register's [19:16], [15:12] and [11:8]; out_ch takes the latched channel.
  - Pulse out_valid, then go to IDLE.
- Result outputs hold their value until the next DONE.
- Only the granted channel's bin is sampled, and only at the grant edge. Later changes to bin do not affect the conversion in flight.
- A req that is still asserted when the block returns to IDLE counts as a new request. Requesters must drop req after seeing ack.
- Requests arriving while busy are not lost; they are considered at the next IDLE cycle.
- No input value is illegal: 255 yields 2/5/5, and no digit exceeds 9.
- Reset values: state IDLE, ptr 0, cnt 0, ack 0, busy 0, out_valid 0, out_ch 0, bcd2/bcd1/bcd0 0, shift register 0.
- Reset asserted mid-conversion aborts it immediately. No out_valid is produced for the aborted request, and arbitration restarts from ptr 0.

## Timing
- Cycle T: IDLE and req sampled non-zero.
- T+1: ack high and busy high; first SHIFT cycle.
- T+1..T+8: the 8 shift iterations.
- T+9: DONE; out_valid high with new digits valid in the same cycle.
- T+10: IDLE; a new grant can be sampled this cycle.
- Latency from req to out_valid: 9 cycles. Throughput: one conversion per 10 cycles.
- All outputs are registered; there is no combinational path from req or bin_flat to any output.
- ptr updates only on a grant.

## Structure
- Package bcd_pkg holds:
  - BIN_W = 8, BCD_DIGITS = 3, SHIFT_W = 20, N_ITER = 8.
  - typedef enum logic [1:0] state_t {IDLE, SHIFT, DONE}.
  - A function add3_adjust(shift_w) for one correction-and-shift step.
- Sub-module rr_arbiter: combinational, parameterised by N_CH.
  - Inputs: req, ptr. Outputs: one-hot grant, grant index, any.
  - Verified standalone.
- The top level holds the FSM, the shift register, cnt, ptr and the output registers.

## Test plan
- Single request: ch2 requests with bin = 255 at T. Expected: ack = 4'b0100 at T+1, out_valid at T+9 with out_ch = 2 and digits 2/5/5, busy low at T+10.
- Simultaneous requests: all four channels request together with values 0, 99, 100, 200. Expected: grants in order 0, 1, 2, 3, ten cycles apart, producing 0/0/0, 0/9/9, 1/0/0 and 2/0/0.
- Fairness: ch0 holds req permanently while ch3 also requests. Expected: grants alternate 0, 3, 0, 3; ch1 and ch2 are never granted.
- Late arrival: ch1 pulses req (held until ack) while a ch0 conversion is busy. Expected: ch1 is granted in the cycle the block returns to IDLE and its out_valid follows 9 cycles later.
- Reset mid-conversion: rst_n driven low at T+5. Expected: all outputs go to 0 asynchronously and no out_valid appears. After release, ch3 requesting alone is granted and ptr restarts from 0.
- Exhaustive sweep: ch1 converts every value 0..255. Expected: each result matches a reference of v/100, (v/10)%10, v%10, and every digit is <= 9.
